replay_sequencer: RTL

REPLAY_SEQUENCER -- requirements
Module: replay_sequencer

---
 rtl/replay_sequencer_pkg.sv | 17 +
 rtl/replay_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/replay_sequencer_pkg.sv
// Shared definitions for the replay sequencer: FSM state encoding and
// default parameter values.
package replay_sequencer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_MAX_PASSES = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_SKIP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/replay_sequencer.sv
// Replays the first len elements of a wrapping re-readable buffer for a
// configured number of passes, then flushes the buffer and pulses done.
module replay_sequencer
  import replay_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned MAX_PASSES = DEF_MAX_PASSES,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned PASS_W    = $clog2(MAX_PASSES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W:0]       cfg_len_i,
  input  logic [PASS_W-1:0]     cfg_passes_i,
  output logic                  busy_o,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  input  logic                  buf_empty_i,
  output logic                  buf_pop_o,
  output logic                  buf_flush_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_elem_o,
  output logic                  out_last_pass_o,
  output logic                  done_o,
  output logic [2:0]            dbg_state_o
);

  // Downstream handshake: an element transfers on a cycle where
  // out_valid_o & out_ready_i; while out_valid_o & ~out_ready_i the data,
  // valid and both last flags are held unchanged.

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [PASS_W-1:0] MAXP_L  = PASS_W'(MAX_PASSES);
  localparam logic [PASS_W-1:0] ONE_P   = PASS_W'(1);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W:0]       r_len;
  logic [ADDR_W:0]       r_elem_cnt;
  logic [ADDR_W:0]       r_skip_cnt;
  logic [PASS_W-1:0]     r_passes;
  logic [PASS_W-1:0]     r_pass_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last_elem;
  logic                  r_last_pass;

  logic [ADDR_W:0]       w_cfg_len;
  logic [PASS_W-1:0]     w_cfg_passes;
  logic                  w_last_elem;
  logic                  w_last_pass;
  logic                  w_skip_last;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_done;

  assign w_cfg_len    = (cfg_len_i > DEPTH_L) ? DEPTH_L : cfg_len_i;
  assign w_cfg_passes = (cfg_passes_i > MAXP_L) ? MAXP_L : cfg_passes_i;
  assign w_last_elem  = (r_elem_cnt == (r_len - ONE_L));
  assign w_last_pass  = (r_pass_cnt == (r_passes - ONE_P));
  assign w_skip_last  = (r_skip_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if ((w_cfg_len == '0) || (w_cfg_passes == '0)) w_next = ST_FLUSH;
          else                                           w_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_pop = ~buf_empty_i & (~r_valid | out_ready_i);
        if (w_pop && w_last_elem) begin
          if (w_last_pass)          w_next = ST_DRAIN;
          else if (r_len < DEPTH_L) w_next = ST_SKIP;
          else                      w_next = ST_STREAM;
        end
      end
      ST_SKIP: begin
        // Discard the unused tail so the read pointer wraps back to entry 0.
        w_pop = ~buf_empty_i;
        if (w_pop && w_skip_last) w_next = ST_STREAM;
      end
      ST_DRAIN: begin
        if (~r_valid | out_ready_i) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        w_done  = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len      <= '0;
      r_passes   <= '0;
      r_elem_cnt <= '0;
      r_pass_cnt <= '0;
      r_skip_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len      <= w_cfg_len;
            r_passes   <= w_cfg_passes;
            r_elem_cnt <= '0;
            r_pass_cnt <= '0;
          end
        end
        ST_STREAM: begin
          if (w_pop) begin
            if (!w_last_elem) begin
              r_elem_cnt <= r_elem_cnt + ONE_L;
            end else if (!w_last_pass) begin
              r_elem_cnt <= '0;
              r_pass_cnt <= r_pass_cnt + ONE_P;
              if (r_len < DEPTH_L) r_skip_cnt <= DEPTH_L - r_len - ONE_L;
            end
          end
        end
        ST_SKIP: begin
          if (w_pop && !w_skip_last) r_skip_cnt <= r_skip_cnt - ONE_L;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last_elem <= 1'b0;
      r_last_pass <= 1'b0;
    end else if ((r_state == ST_STREAM) && w_pop) begin
      r_data      <= buf_data_i;
      r_valid     <= 1'b1;
      r_last_elem <= w_last_elem;
      r_last_pass <= w_last_pass;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign busy_o          = (r_state != ST_IDLE);
  assign buf_pop_o       = w_pop;
  assign buf_flush_o     = w_flush;
  assign done_o          = w_done;
  assign out_valid_o     = r_valid;
  assign out_data_o      = r_data;
  assign out_last_elem_o = r_last_elem;
  assign out_last_pass_o = r_last_pass;
  assign dbg_state_o     = r_state;

endmodule
